// File: rtl/cs_addsub_reg.sv
// cs_addsub_reg: registered WIDTH-bit carry-select adder/subtractor.
// Subtraction is a + ~b + ~c_in, so c_out=1 means "no borrow" and c_in acts
// as a borrow-in. Segment 0 ripples from the conditioned carry-in; every
// higher segment precomputes both carry-in cases and muxes on the carry
// arriving from the segment below.
module cs_addsub_reg #(
  parameter int WIDTH = 4,
  parameter int BLOCK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             mode,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             out_valid
);

  // Number of segments; the top one is shorter when BLOCK does not divide WIDTH.
  localparam int NSEG = (WIDTH + BLOCK - 1) / BLOCK;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [NSEG:0]    seg_carry;   // selected carry entering each segment
  logic [WIDTH-1:0] sum_comb;
  logic             msb_cin;     // carry into the MSB, needed for signed overflow

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  assign b_eff        = b ^ {WIDTH{mode}};
  assign cin_eff      = c_in ^ mode;
  assign seg_carry[0] = cin_eff;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NSEG; gi++) begin : g_seg
      localparam int LO  = gi * BLOCK;
      localparam int LEN = ((WIDTH - LO) < BLOCK) ? (WIDTH - LO) : BLOCK;

      if (gi == 0) begin : g_first
        // Plain ripple chain: its carry-in is known as soon as the inputs are.
        logic [LEN:0] c;
        assign c[0] = seg_carry[0];
        for (gj = 0; gj < LEN; gj++) begin : g_bit
          assign sum_comb[LO+gj] = a[LO+gj] ^ b_eff[LO+gj] ^ c[gj];
          assign c[gj+1] = (a[LO+gj] & b_eff[LO+gj]) |
                           (c[gj] & (a[LO+gj] ^ b_eff[LO+gj]));
        end
        assign seg_carry[gi+1] = c[LEN];
        if (gi == NSEG - 1) begin : g_msb
          assign msb_cin = c[LEN-1];
        end
      end else begin : g_sel
        // Two speculative chains, one per possible carry-in.
        logic [LEN:0]   c0, c1;
        logic [LEN-1:0] s0, s1;
        assign c0[0] = 1'b0;
        assign c1[0] = 1'b1;
        for (gj = 0; gj < LEN; gj++) begin : g_bit
          assign s0[gj] = a[LO+gj] ^ b_eff[LO+gj] ^ c0[gj];
          assign s1[gj] = a[LO+gj] ^ b_eff[LO+gj] ^ c1[gj];
          assign c0[gj+1] = (a[LO+gj] & b_eff[LO+gj]) |
                            (c0[gj] & (a[LO+gj] ^ b_eff[LO+gj]));
          assign c1[gj+1] = (a[LO+gj] & b_eff[LO+gj]) |
                            (c1[gj] & (a[LO+gj] ^ b_eff[LO+gj]));
          assign sum_comb[LO+gj] = seg_carry[gi] ? s1[gj] : s0[gj];
        end
        assign seg_carry[gi+1] = seg_carry[gi] ? c1[LEN] : c0[LEN];
        if (gi == NSEG - 1) begin : g_msb
          assign msb_cin = seg_carry[gi] ? c1[LEN-1] : c0[LEN-1];
        end
      end
    end
  endgenerate

  // Next-state: capture a new result only on valid input, otherwise hold.
  always_comb begin
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d   = sum_comb;
      c_out_d = seg_carry[NSEG];
      ovf_d   = msb_cin ^ seg_carry[NSEG];
    end
  end

  // Output registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign overflow  = ovf_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_cs_addsub_reg.sv
// Bench for cs_addsub_reg: six instances (WIDTH/BLOCK = 4/2, 4/1, 4/3, 4/4,
// 16/4, 7/3) share control inputs; an arithmetic reference model predicts
// every instance's outputs each cycle, and directed steps pin literal values.
module tb_cs_addsub_reg;

  logic        clk;
  logic        rst_n, in_valid, c_in, mode;
  logic [3:0]  a4, b4;
  logic [15:0] a16, b16;
  logic [6:0]  a7, b7;

  logic [3:0]  s4 [4];
  logic        co4 [4], ov4 [4], vl4 [4];
  logic [15:0] s16;
  logic        co16, ov16, vl16;
  logic [6:0]  s7;
  logic        co7, ov7, vl7;

  int checks = 0;
  int errors = 0;
  bit armed = 0;

  localparam int WID [6] = '{4, 4, 4, 4, 16, 7};
  logic [63:0] exp_sum [6];
  logic        exp_co [6], exp_ov [6], exp_vld [6];

  cs_addsub_reg #(.WIDTH(4), .BLOCK(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a4), .b(b4), .c_in(c_in), .mode(mode),
    .sum(s4[0]), .c_out(co4[0]), .overflow(ov4[0]), .out_valid(vl4[0]));
  cs_addsub_reg #(.WIDTH(4), .BLOCK(1)) dut_b1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a4), .b(b4), .c_in(c_in), .mode(mode),
    .sum(s4[1]), .c_out(co4[1]), .overflow(ov4[1]), .out_valid(vl4[1]));
  cs_addsub_reg #(.WIDTH(4), .BLOCK(3)) dut_b3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a4), .b(b4), .c_in(c_in), .mode(mode),
    .sum(s4[2]), .c_out(co4[2]), .overflow(ov4[2]), .out_valid(vl4[2]));
  cs_addsub_reg #(.WIDTH(4), .BLOCK(4)) dut_b4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a4), .b(b4), .c_in(c_in), .mode(mode),
    .sum(s4[3]), .c_out(co4[3]), .overflow(ov4[3]), .out_valid(vl4[3]));
  cs_addsub_reg #(.WIDTH(16), .BLOCK(4)) dut_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a16), .b(b16), .c_in(c_in), .mode(mode),
    .sum(s16), .c_out(co16), .overflow(ov16), .out_valid(vl16));
  cs_addsub_reg #(.WIDTH(7), .BLOCK(3)) dut_w7 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a7), .b(b7), .c_in(c_in), .mode(mode),
    .sum(s7), .c_out(co7), .overflow(ov7), .out_valid(vl7));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, expv);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic, no carry chains.
  function automatic void ref_op(input int w, input longint a, input longint b,
                                 input bit ci, input bit md,
                                 output longint s, output bit co, output bit ov);
    longint m, half, sa, sb, r, sr;
    m    = longint'(1) << w;
    half = m / 2;
    sa   = (a >= half) ? a - m : a;
    sb   = (b >= half) ? b - m : b;
    if (!md) begin
      r  = a + b + longint'(ci);
      sr = sa + sb + longint'(ci);
      co = (r >= m);
    end else begin
      r  = a - b - longint'(ci);
      sr = sa - sb - longint'(ci);
      co = (r >= 0);
    end
    s  = r & (m - 1);
    ov = (sr >= half) || (sr < -half);
  endfunction

  function automatic longint op_a(input int i);
    return (i < 4) ? longint'(a4) : (i == 4) ? longint'(a16) : longint'(a7);
  endfunction
  function automatic longint op_b(input int i);
    return (i < 4) ? longint'(b4) : (i == 4) ? longint'(b16) : longint'(b7);
  endfunction

  // Model update at each edge from the inputs presented to that edge.
  always @(posedge clk) begin
    longint s;
    bit co, ov;
    armed <= armed | !rst_n;
    for (int i = 0; i < 6; i++) begin
      if (!rst_n) begin
        exp_sum[i] <= '0;
        exp_co[i]  <= 1'b0;
        exp_ov[i]  <= 1'b0;
        exp_vld[i] <= 1'b0;
      end else begin
        if (in_valid) begin
          ref_op(WID[i], op_a(i), op_b(i), c_in, mode, s, co, ov);
          exp_sum[i] <= s;
          exp_co[i]  <= co;
          exp_ov[i]  <= ov;
        end
        exp_vld[i] <= in_valid;
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    logic [63:0] as;
    logic ac, ao, av;
    if (armed) begin
      for (int i = 0; i < 6; i++) begin
        if (i < 4) begin
          as = 64'(s4[i]); ac = co4[i]; ao = ov4[i]; av = vl4[i];
        end else if (i == 4) begin
          as = 64'(s16); ac = co16; ao = ov16; av = vl16;
        end else begin
          as = 64'(s7); ac = co7; ao = ov7; av = vl7;
        end
        chk($sformatf("model_sum[%0d]", i), as, exp_sum[i]);
        chk($sformatf("model_cout[%0d]", i), 64'(ac), 64'(exp_co[i]));
        chk($sformatf("model_ovf[%0d]", i), 64'(ao), 64'(exp_ov[i]));
        chk($sformatf("model_vld[%0d]", i), 64'(av), 64'(exp_vld[i]));
      end
    end
  end

  // Wide-instance operands are refreshed randomly every cycle.
  initial begin
    a16 = 16'($urandom); b16 = 16'($urandom);
    a7  = 7'($urandom);  b7  = 7'($urandom);
    forever begin
      @(posedge clk);
      #1;
      a16 = 16'($urandom); b16 = 16'($urandom);
      a7  = 7'($urandom);  b7  = 7'($urandom);
    end
  end

  // One operation per edge; optional literal check of the 4/2 instance.
  task automatic go(input bit rn, input bit vld, input logic [3:0] aa, input logic [3:0] bb,
                    input bit ci, input bit md, input logic [3:0] es, input bit eco,
                    input bit eov, input bit evld, input string nm, input bit lit);
    rst_n = rn; in_valid = vld; a4 = aa; b4 = bb; c_in = ci; mode = md;
    @(posedge clk);
    #1;
    if (lit) begin
      chk({nm, "_sum"}, 64'(s4[0]), 64'(es));
      chk({nm, "_cout"}, 64'(co4[0]), 64'(eco));
      chk({nm, "_ovf"}, 64'(ov4[0]), 64'(eov));
      chk({nm, "_vld"}, 64'(vl4[0]), 64'(evld));
      $display("%s: a=%b b=%b c_in=%b mode=%b -> sum=%b c_out=%b ovf=%b vld=%b",
               nm, aa, bb, ci, md, s4[0], co4[0], ov4[0], vl4[0]);
    end
  endtask

  initial begin
    int x;
    go(0, 1, 4'b1001, 4'b0110, 1, 0, 4'b0000, 0, 0, 0, "rst1", 0);
    go(0, 1, 4'b1111, 4'b1111, 1, 1, 4'b0000, 0, 0, 0, "rst2", 1);
    go(1, 1, 4'b0001, 4'b0001, 0, 0, 4'b0010, 0, 0, 1, "add1", 1);
    // 12-5-1 = 6; signed -4-5-1 = -10 leaves the 4-bit range.
    go(1, 1, 4'b1100, 4'b0101, 1, 1, 4'b0110, 1, 1, 1, "subb", 1);
    go(1, 1, 4'b1100, 4'b0101, 0, 0, 4'b0001, 1, 0, 1, "addw", 1);
    go(1, 1, 4'b1111, 4'b0000, 1, 0, 4'b0000, 1, 0, 1, "prop", 1);
    go(1, 1, 4'b0011, 4'b0101, 0, 1, 4'b1110, 0, 0, 1, "borr", 1);
    go(1, 1, 4'b0111, 4'b0001, 0, 0, 4'b1000, 0, 1, 1, "ovfa", 1);
    go(1, 1, 4'b1000, 4'b0001, 0, 1, 4'b0111, 1, 1, 1, "ovfs", 1);
    go(1, 0, 4'b0101, 4'b1010, 1, 0, 4'b0111, 1, 1, 0, "hold1", 1);
    go(1, 0, 4'b1111, 4'b1111, 0, 1, 4'b0111, 1, 1, 0, "hold2", 1);
    go(1, 1, 4'b0010, 4'b0011, 0, 0, 4'b0101, 0, 0, 1, "b2b1", 1);
    go(1, 1, 4'b0110, 4'b0011, 1, 0, 4'b1010, 0, 1, 1, "b2b2", 1);
    go(0, 1, 4'b0111, 4'b0111, 0, 0, 4'b0000, 0, 0, 0, "midrst", 1);
    // Exhaustive 4-bit sweep; the model checks all four 4-bit instances.
    for (x = 0; x < 1024; x++)
      go(1, 1, x[3:0], x[7:4], x[8], x[9], 4'b0000, 0, 0, 0, "exh", 0);
    // Random traffic with valid gaps and occasional resets.
    for (int k = 0; k < 300; k++)
      go(($urandom % 32) != 0, ($urandom % 4) != 0, 4'($urandom), 4'($urandom),
         1'($urandom), 1'($urandom), 4'b0000, 0, 0, 0, "rnd", 0);
    go(1, 0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, "drain", 0);
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
